// File: rtl/t03_spi_pkg.sv
// Shared types and default sizing for the t03 SPI master slice.
package t03_spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

  localparam int XFER_W_DEF = 32;
  localparam int DIV_W_DEF  = 32;

endpackage

// File: rtl/t03_spi_clkgen.sv
// Half-period timer: latches the divider on clear and pulses 'tick' every clkdiv+1 enabled cycles.
module t03_spi_clkgen
  import t03_spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  // One extra bit so clkdiv = all-ones still yields a period of 2^DIV_W without wrapping.
  logic [DIV_W:0]   cnt;
  logic [DIV_W-1:0] div_q;

  always_comb tick = en && (cnt == {1'b0, div_q});

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clear) begin
      cnt   <= '0;
      div_q <= div;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t03_spi_master.sv
// Mode-0 SPI master, one full-duplex MSB-first frame per accepted start.
// `define SPI_LOOPBACK_EN to sample the internal mosi instead of the miso pad.
module t03_spi_master
  import t03_spi_pkg::*;
#(
  parameter int XFER_W = XFER_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XFER_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              miso,
  output logic [XFER_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int              CNT_W    = $clog2(XFER_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(XFER_W);

  spi_state_t        state;
  logic [XFER_W-1:0] tx_sh;
  logic [XFER_W-1:0] rx_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;
  logic              tick;
  logic              sample;

  assign accept = start && !busy;
  assign mosi   = tx_sh[XFER_W-1];

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample      = mosi;
`else
  assign sample = miso;
`endif

  t03_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (busy),
    .div   (clkdiv),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state   <= SETUP;
          busy    <= 1'b1;
          cs_n    <= 1'b0;
          tx_sh   <= tx_data;
          rx_sh   <= '0;
          bit_cnt <= '0;
        end
        SETUP: if (tick) begin
          state   <= SHIFT;
          sclk    <= 1'b1;
          rx_sh   <= {rx_sh[XFER_W-2:0], sample};
          bit_cnt <= bit_cnt + 1'b1;
        end
        SHIFT: if (tick) begin
          if (sclk) begin
            sclk <= 1'b0;
            // The last bit stays on mosi through the trailing low half-period and HOLD.
            if (bit_cnt != LAST_BIT) tx_sh <= tx_sh << 1;
          end else if (bit_cnt == LAST_BIT) begin
            state <= HOLD;
          end else begin
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[XFER_W-2:0], sample};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HOLD: if (tick) begin
          state   <= IDLE;
          busy    <= 1'b0;
          cs_n    <= 1'b1;
          done    <= 1'b1;
          rx_data <= rx_sh;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t03_spi_master.sv
// Directed bench for t03_spi_master: frame timing, data paths, ignored starts, back-to-back frames, reset.
`timescale 1ns/1ps
module tb_t03_spi_master;

  localparam int W  = 32;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic [DW-1:0] clkdiv  = '0;
  logic          miso    = 1'b0;
  logic [W-1:0]  rx_data;
  logic          busy, done, sclk, mosi, cs_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model state and frame observations.
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] slave_sh   = '0;
  bit           slave_loaded = 1'b0;

  int           busy_n, rises, per_min, per_max, unstable;
  logic [W-1:0] cap;
  bit           got_done;
  logic         first_busy, first_csn, first_mosi, first_done, done_busy, done_csn;

  always #5 clk = ~clk;

  t03_spi_master dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .clkdiv  (clkdiv),
    .miso    (miso),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n)
  );

  // Mode-0 slave: MSB presented on cs_n fall, next bit after each sclk fall.
  always @(posedge cs_n or negedge cs_n or negedge sclk) begin
    if (cs_n !== 1'b0) begin
      slave_loaded = 1'b0;
    end else if (!slave_loaded) begin
      slave_sh     = slave_word;
      slave_loaded = 1'b1;
    end else begin
      slave_sh = slave_sh << 1;
    end
    miso = slave_sh[W-1];
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rx(input logic [W-1:0] tx, input logic [W-1:0] slave);
`ifdef SPI_LOOPBACK_EN
    exp_rx = tx;
`else
    exp_rx = slave;
`endif
  endfunction

  // Called at the negedge where start was raised; returns at the negedge that shows done.
  task automatic watch_frame(input int h, input bit inject, input bit chain,
                             input logic [W-1:0] ntx, input logic [DW-1:0] ndiv,
                             input logic [W-1:0] nslave);
    int   limit = (2*W + 2)*h + 40;
    int   cyc = 0;
    int   last_rise = -1;
    logic prev_sclk, prev_mosi;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; rises = 0; cap = '0; per_min = 1 << 30; per_max = 0; unstable = 0;
    got_done = 1'b0;
    first_busy = busy; first_csn = cs_n; first_mosi = mosi; first_done = done;
    done_busy = 1'b1; done_csn = 1'b0;
    prev_sclk = sclk; prev_mosi = mosi;
    while (!got_done && cyc < limit) begin
      cyc++;
      if (busy) busy_n++;
      if (sclk && !prev_sclk) begin
        rises++;
        cap = {cap[W-2:0], mosi};
        if (mosi !== prev_mosi) unstable++;
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (inject) begin
        if (cyc == 20) begin
          start   = 1'b1;
          tx_data = 32'hFFFF_0000;
          clkdiv  = 7;
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        got_done  = 1'b1;
        done_busy = busy;
        done_csn  = cs_n;
        if (chain) begin
          tx_data    = ntx;
          clkdiv     = ndiv;
          slave_word = nslave;
          start      = 1'b1;
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      if (!got_done) @(negedge clk);
    end
  endtask

  task automatic frame_checks(input string tag, input logic [W-1:0] tx, input logic [W-1:0] rx, input int h);
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_busy_cycles"}, busy_n, (2*W + 2)*h);
    check({tag, "_rises"}, rises, W);
    check({tag, "_mosi_stream"}, cap, tx);
    check({tag, "_rx_data"}, rx_data, rx);
    check({tag, "_mosi_stable"}, unstable, 0);
    check({tag, "_period_min"}, per_min, 2*h);
    check({tag, "_period_max"}, per_max, 2*h);
    check({tag, "_setup_mosi"}, first_mosi, tx[W-1]);
    check({tag, "_setup_busy_csn"}, {first_busy, first_csn}, 2'b10);
    check({tag, "_done_exit"}, {done_busy, done_csn}, 2'b01);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10000);
    check("reset_rx_data", rx_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Frame at clk/2 (loopback vector when SPI_LOOPBACK_EN).
    tx_data = 32'hA5A5_0F0F; clkdiv = 0; slave_word = 32'h5A5A_F0F0; start = 1'b1;
    watch_frame(1, 1'b0, 1'b0, '0, '0, '0);
    frame_checks("div0", 32'hA5A5_0F0F, exp_rx(32'hA5A5_0F0F, 32'h5A5A_F0F0), 1);
    @(negedge clk);
    check("div0_done_width", done, 1'b0);

    // clkdiv=3: 8-cycle sclk period, 264 busy cycles.
    tx_data = 32'hC3C3_3C3C; clkdiv = 3; slave_word = 32'h1234_5678; start = 1'b1;
    watch_frame(4, 1'b0, 1'b0, '0, '0, '0);
    frame_checks("div3", 32'hC3C3_3C3C, exp_rx(32'hC3C3_3C3C, 32'h1234_5678), 4);

    // Start with new tx_data/clkdiv mid-frame is ignored.
    @(negedge clk);
    tx_data = 32'h0F0F_AAAA; clkdiv = 1; slave_word = 32'hDEAD_BEEF; start = 1'b1;
    watch_frame(2, 1'b1, 1'b0, '0, '0, '0);
    frame_checks("ignore", 32'h0F0F_AAAA, exp_rx(32'h0F0F_AAAA, 32'hDEAD_BEEF), 2);
    clkdiv = 0;
    repeat (5) @(negedge clk);
    check("ignore_no_second_frame", {busy, cs_n}, 2'b01);

    // Start in the done cycle, chained into the 8000_0001 mosi frame at clkdiv=1.
    tx_data = 32'h1357_9BDF; clkdiv = 0; slave_word = 32'h2468_ACE0; start = 1'b1;
    watch_frame(1, 1'b0, 1'b1, 32'h8000_0001, 1, 32'h7FFF_FFFE);
    frame_checks("chain_a", 32'h1357_9BDF, exp_rx(32'h1357_9BDF, 32'h2468_ACE0), 1);
    watch_frame(2, 1'b0, 1'b0, '0, '0, '0);
    check("chain_done_one_cycle", first_done, 1'b0);
    frame_checks("mosi_8001", 32'h8000_0001, exp_rx(32'h8000_0001, 32'h7FFF_FFFE), 2);

    // Reset at cycle 10 of a clkdiv=0 frame.
    @(negedge clk);
    tx_data = 32'h0F0F_0F0F; clkdiv = 0; slave_word = 32'h3333_CCCC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10000);
    check("midreset_rx_data", rx_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_busy", busy_cnt, 0);

    // Clean frame after reset.
    tx_data = 32'h0000_FFFF; clkdiv = 2; slave_word = 32'hFFFF_0000; start = 1'b1;
    watch_frame(3, 1'b0, 1'b0, '0, '0, '0);
    frame_checks("post_reset", 32'h0000_FFFF, exp_rx(32'h0000_FFFF, 32'hFFFF_0000), 3);
    @(negedge clk);
    check("post_reset_done_width", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
